cpu_prog_loader: RTL and testbench

CPU_PROG_LOADER -- requirements
Module: cpu_prog_loader

---
 rtl/cpu_prog_loader_pkg.sv | 36 +++
 rtl/cpu_prog_uart_rx.sv | 107 ++++++++++
 rtl/cpu_prog_loader.sv | 129 ++++++++++++
 tb/tb_cpu_prog_loader.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_prog_loader_pkg.sv
// cpu_prog_loader_pkg
//   Shared types, constants and helpers for the serial program loader:
//   loader FSM state enum, UART receiver state enum, frame length bounds
//   and the running XOR checksum step.
package cpu_prog_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN,
      ST_DATA,
      ST_CSUM,
      ST_RUN,
      ST_ERR
   } ld_state_e;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_e;

   // Smallest legal LEN byte; the largest is the full memory depth.
   localparam int LEN_MIN = 1;

   function automatic int len_max(input int addr_w);
      return 1 << addr_w;
   endfunction

   // The frame checksum is a plain XOR of the data bytes.
   function automatic logic [7:0] csum_step(input logic [7:0] acc,
                                            input logic [7:0] b);
      return acc ^ b;
   endfunction

endpackage

// File: rtl/cpu_prog_uart_rx.sv
// cpu_prog_uart_rx
//   8N1 UART receiver, idle high, LSB first, CLK_DIV clocks per bit.
//   Ports:
//     clk_i, rst_ni    clock / async active-low reset
//     rx_i             raw serial input (synchronized here)
//     byte_o           last received byte (stable until the next one)
//     byte_valid_o     1-cycle pulse: byte_o holds a good frame
//     frame_err_o      1-cycle pulse: stop bit sampled low
module cpu_prog_uart_rx
   import cpu_prog_loader_pkg::*;
#(
   parameter int CLK_DIV = 16
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       rx_i,
   output logic [7:0] byte_o,
   output logic       byte_valid_o,
   output logic       frame_err_o
);

   localparam int TW   = $clog2(CLK_DIV);
   localparam int HALF = CLK_DIV / 2;

   rx_state_e     st_q, st_d;
   logic [1:0]    sync_q;
   logic          prev_q;
   logic [TW-1:0] tmr_q, tmr_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    sh_q, sh_d;
   logic          vld_q, vld_d;
   logic          ferr_q, ferr_d;
   logic          rx_s;
   logic          fall;

   assign rx_s = sync_q[1];
   // Edge-triggered start so a line held low after a bad stop bit does
   // not retrigger endlessly.
   assign fall = prev_q & ~rx_s;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= 2'b11;
         prev_q <= 1'b1;
         st_q   <= RX_IDLE;
         tmr_q  <= '0;
         bit_q  <= '0;
         sh_q   <= '0;
         vld_q  <= 1'b0;
         ferr_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], rx_i};
         prev_q <= rx_s;
         st_q   <= st_d;
         tmr_q  <= tmr_d;
         bit_q  <= bit_d;
         sh_q   <= sh_d;
         vld_q  <= vld_d;
         ferr_q <= ferr_d;
      end
   end

   always_comb begin
      st_d   = st_q;
      tmr_d  = tmr_q + TW'(1);
      bit_d  = bit_q;
      sh_d   = sh_q;
      vld_d  = 1'b0;
      ferr_d = 1'b0;
      case (st_q)
         RX_IDLE: begin
            tmr_d = '0;
            if (fall) st_d = RX_START;
         end
         RX_START: begin
            // Mid-bit re-check: a high sample was a glitch, drop it quietly.
            if (tmr_q == TW'(HALF - 1)) begin
               tmr_d = '0;
               bit_d = '0;
               st_d  = rx_s ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (tmr_q == TW'(CLK_DIV - 1)) begin
               tmr_d = '0;
               sh_d  = {rx_s, sh_q[7:1]};
               bit_d = bit_q + 3'd1;
               if (bit_q == 3'd7) st_d = RX_STOP;
            end
         end
         RX_STOP: begin
            if (tmr_q == TW'(CLK_DIV - 1)) begin
               tmr_d = '0;
               st_d  = RX_IDLE;
               if (rx_s) vld_d  = 1'b1;
               else      ferr_d = 1'b1;
            end
         end
         default: st_d = RX_IDLE;
      endcase
   end

   assign byte_o       = sh_q;
   assign byte_valid_o = vld_q;
   assign frame_err_o  = ferr_q;

endmodule

// File: rtl/cpu_prog_loader.sv
// cpu_prog_loader
//   Receives a program over UART (LEN, N data bytes, XOR CSUM) into a
//   2^ADDR_W byte memory while holding the CPU in reset; releases the CPU
//   once the checksum matches.
//   Ports:
//     wb_clk_i   system clock            rst_n     async active-low reset
//     uart_rx    serial program input    load_req  start a new load
//     addr_bus   CPU fetch address       data_bus  fetched byte
//     cpu_rst    CPU hold-in-reset       busy      frame in progress
//     done       program loaded (RUN)    err       load failed (ERR)
module cpu_prog_loader
   import cpu_prog_loader_pkg::*;
#(
   parameter int ADDR_W  = 6,
   parameter int CLK_DIV = 16
) (
   input  logic       wb_clk_i,
   input  logic       rst_n,
   input  logic       uart_rx,
   input  logic       load_req,
   input  logic [9:0] addr_bus,
   output logic [7:0] data_bus,
   output logic       cpu_rst,
   output logic       busy,
   output logic       done,
   output logic       err
);

   localparam int PW      = ADDR_W + 1;   // holds N up to the full depth
   localparam int DEPTH   = 1 << ADDR_W;
   localparam int LEN_MAX = len_max(ADDR_W);

   ld_state_e   st_q, st_d;
   logic [PW-1:0] ptr_q, ptr_d;
   logic [PW-1:0] len_q, len_d;
   logic [7:0]  xor_q, xor_d;
   logic        mem_we;
   logic [7:0]  rx_byte;
   logic        rx_vld;
   logic        rx_ferr;
   logic [7:0]  mem [DEPTH];

   cpu_prog_uart_rx #(.CLK_DIV(CLK_DIV)) u_rx (
      .clk_i        (wb_clk_i),
      .rst_ni       (rst_n),
      .rx_i         (uart_rx),
      .byte_o       (rx_byte),
      .byte_valid_o (rx_vld),
      .frame_err_o  (rx_ferr)
   );

   always_ff @(posedge wb_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         st_q  <= ST_IDLE;
         ptr_q <= '0;
         len_q <= '0;
         xor_q <= '0;
      end else begin
         st_q  <= st_d;
         ptr_q <= ptr_d;
         len_q <= len_d;
         xor_q <= xor_d;
      end
   end

   always_comb begin
      st_d   = st_q;
      ptr_d  = ptr_q;
      len_d  = len_q;
      xor_d  = xor_q;
      mem_we = 1'b0;
      case (st_q)
         // load_req is only honoured outside an active frame.
         ST_IDLE, ST_RUN, ST_ERR: begin
            if (load_req) begin
               st_d  = ST_LEN;
               ptr_d = '0;
               xor_d = '0;
            end
         end
         ST_LEN: begin
            if (rx_ferr) begin
               st_d = ST_ERR;
            end else if (rx_vld) begin
               if (int'(rx_byte) < LEN_MIN || int'(rx_byte) > LEN_MAX) begin
                  st_d = ST_ERR;
               end else begin
                  len_d = PW'(rx_byte);
                  st_d  = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (rx_ferr) begin
               st_d = ST_ERR;
            end else if (rx_vld) begin
               mem_we = 1'b1;
               xor_d  = csum_step(xor_q, rx_byte);
               ptr_d  = ptr_q + PW'(1);
               // ptr stops at N, which always fits in PW bits.
               if (ptr_q == len_q - PW'(1)) st_d = ST_CSUM;
            end
         end
         ST_CSUM: begin
            if (rx_ferr) begin
               st_d = ST_ERR;
            end else if (rx_vld) begin
               st_d = (rx_byte == xor_q) ? ST_RUN : ST_ERR;
            end
         end
         default: st_d = ST_IDLE;
      endcase
   end

   // No reset on the array: a reset must not wipe a loaded program.
   always_ff @(posedge wb_clk_i) begin
      if (mem_we) mem[ptr_q[ADDR_W-1:0]] <= rx_byte;
   end

   // Asynchronous read: a same-cycle write is seen only after the edge.
   assign data_bus = ((addr_bus >> ADDR_W) == '0) ? mem[addr_bus[ADDR_W-1:0]]
                                                  : 8'h00;

   assign cpu_rst = (st_q != ST_RUN);
   assign busy    = (st_q == ST_LEN) || (st_q == ST_DATA) || (st_q == ST_CSUM);
   assign done    = (st_q == ST_RUN);
   assign err     = (st_q == ST_ERR);

endmodule

// File: tb/tb_cpu_prog_loader.sv
// tb_cpu_prog_loader
//   Table-driven frames plus hand sequences for framing error, RUN-state
//   reads and reload, asynchronous reset mid-frame and a full-depth load.
module tb_cpu_prog_loader;

   localparam int ADDR_W  = 6;
   localparam int CLK_DIV = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       uart_rx = 1'b1;
   logic       load_req = 1'b0;
   logic [9:0] addr_bus = '0;
   logic [7:0] data_bus;
   logic       cpu_rst, busy, done, err;

   int checks = 0;
   int passes = 0;

   typedef struct {
      int              n;
      logic [5:0][7:0] b;      // b[0] is sent first
      logic            e_done;
      logic            e_err;
      logic [2:0][7:0] e_mem;  // expected mem[0..2] afterwards
   } vec_t;

   vec_t vq[$];

   cpu_prog_loader #(.ADDR_W(ADDR_W), .CLK_DIV(CLK_DIV)) dut (
      .wb_clk_i (clk),
      .rst_n    (rst_n),
      .uart_rx  (uart_rx),
      .load_req (load_req),
      .addr_bus (addr_bus),
      .data_bus (data_bus),
      .cpu_rst  (cpu_rst),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
      else passes++;
   endtask

   task automatic add_vec(input int n, input logic [7:0] b0, b1, b2, b3, b4,
                          input logic d, e, input logic [7:0] m0, m1, m2);
      vec_t v;
      v.n = n;
      v.b = {8'h00, b4, b3, b2, b1, b0};
      v.e_done = d;
      v.e_err = e;
      v.e_mem = {m2, m1, m0};
      vq.push_back(v);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      @(negedge clk) uart_rx = 1'b0;
      repeat (CLK_DIV - 1) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk) uart_rx = b[i];
         repeat (CLK_DIV - 1) @(negedge clk);
      end
      @(negedge clk) uart_rx = stop;
      repeat (CLK_DIV - 1) @(negedge clk);
      @(negedge clk) uart_rx = 1'b1;
      repeat (CLK_DIV / 2) @(negedge clk);
   endtask

   task automatic pulse_load();
      @(negedge clk) load_req = 1'b1;
      @(negedge clk) load_req = 1'b0;
   endtask

   task automatic rd(input logic [9:0] a, output logic [7:0] d);
      @(negedge clk) addr_bus = a;
      #1 d = data_bus;
   endtask

   initial begin
      logic [7:0] d;
      logic [7:0] x;
      vec_t v;

      //        n  b0     b1     b2     b3     b4     done  err   m0     m1     m2
      add_vec(5, 8'h03, 8'hA9, 8'h05, 8'h20, 8'h8C, 1'b1, 1'b0, 8'hA9, 8'h05, 8'h20);
      add_vec(4, 8'h02, 8'h11, 8'h22, 8'h00, 8'h00, 1'b0, 1'b1, 8'h11, 8'h22, 8'h20);
      add_vec(1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h11, 8'h22, 8'h20);
      add_vec(1, 8'h41, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h11, 8'h22, 8'h20);
      add_vec(3, 8'h01, 8'h5A, 8'h5A, 8'h00, 8'h00, 1'b1, 1'b0, 8'h5A, 8'h22, 8'h20);
      add_vec(4, 8'h02, 8'h7E, 8'h81, 8'hFF, 8'h00, 1'b1, 1'b0, 8'h7E, 8'h81, 8'h20);

      // Reset state
      #12;
      chk("rst_cpu_rst", {7'd0, cpu_rst}, 8'd1);
      chk("rst_busy",    {7'd0, busy},    8'd0);
      chk("rst_done",    {7'd0, done},    8'd0);
      chk("rst_err",     {7'd0, err},     8'd0);
      @(negedge clk) rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle_busy", {7'd0, busy}, 8'd0);

      // Table-driven frames
      foreach (vq[i]) begin
         v = vq[i];
         pulse_load();
         chk($sformatf("v%0d_busy_load", i), {7'd0, busy}, 8'd1);
         chk($sformatf("v%0d_rst_load", i), {7'd0, cpu_rst}, 8'd1);
         chk($sformatf("v%0d_done_load", i), {7'd0, done}, 8'd0);
         for (int j = 0; j < v.n; j++) send_byte(v.b[j], 1'b1);
         repeat (2) @(negedge clk);
         chk($sformatf("v%0d_done", i), {7'd0, done}, {7'd0, v.e_done});
         chk($sformatf("v%0d_err", i), {7'd0, err}, {7'd0, v.e_err});
         chk($sformatf("v%0d_cpu_rst", i), {7'd0, cpu_rst}, {7'd0, ~v.e_done});
         chk($sformatf("v%0d_busy", i), {7'd0, busy}, 8'd0);
         for (int k = 0; k < 3; k++) begin
            rd(10'(k), d);
            chk($sformatf("v%0d_mem%0d", i, k), d, v.e_mem[k]);
         end
      end

      // Stop bit low on the 2nd data byte: ERR, mem[1] untouched
      pulse_load();
      send_byte(8'h03, 1'b1);
      send_byte(8'hAA, 1'b1);
      send_byte(8'hBB, 1'b0);
      repeat (2) @(negedge clk);
      chk("ferr_err", {7'd0, err}, 8'd1);
      chk("ferr_busy", {7'd0, busy}, 8'd0);
      chk("ferr_cpu_rst", {7'd0, cpu_rst}, 8'd1);
      rd(10'd0, d); chk("ferr_mem0", d, 8'hAA);
      rd(10'd1, d); chk("ferr_mem1", d, 8'h81);

      // RUN: out-of-range reads, then reload
      pulse_load();
      send_byte(8'h01, 1'b1);
      send_byte(8'h5A, 1'b1);
      send_byte(8'h5A, 1'b1);
      repeat (2) @(negedge clk);
      chk("run_done", {7'd0, done}, 8'd1);
      chk("run_cpu_rst", {7'd0, cpu_rst}, 8'd0);
      rd(10'h040, d); chk("run_rd_040", d, 8'h00);
      rd(10'h3C0, d); chk("run_rd_3c0", d, 8'h00);
      rd(10'h000, d); chk("run_rd_000", d, 8'h5A);
      pulse_load();
      chk("reload_cpu_rst", {7'd0, cpu_rst}, 8'd1);
      chk("reload_busy", {7'd0, busy}, 8'd1);
      chk("reload_done", {7'd0, done}, 8'd0);
      pulse_load();  // ignored while in LEN
      chk("reload_ign_busy", {7'd0, busy}, 8'd1);

      // Async reset mid-DATA, then frames need a fresh load_req
      send_byte(8'h04, 1'b1);
      send_byte(8'h11, 1'b1);
      chk("mid_busy", {7'd0, busy}, 8'd1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", {7'd0, busy}, 8'd0);
      chk("arst_cpu_rst", {7'd0, cpu_rst}, 8'd1);
      chk("arst_done", {7'd0, done}, 8'd0);
      chk("arst_err", {7'd0, err}, 8'd0);
      @(negedge clk) rst_n = 1'b1;
      send_byte(8'h02, 1'b1);
      send_byte(8'h33, 1'b1);
      send_byte(8'h44, 1'b1);
      send_byte(8'h77, 1'b1);
      repeat (2) @(negedge clk);
      chk("noreq_busy", {7'd0, busy}, 8'd0);
      chk("noreq_done", {7'd0, done}, 8'd0);
      pulse_load();
      send_byte(8'h02, 1'b1);
      send_byte(8'h33, 1'b1);
      send_byte(8'h44, 1'b1);
      send_byte(8'h77, 1'b1);
      repeat (2) @(negedge clk);
      chk("post_rst_done", {7'd0, done}, 8'd1);
      rd(10'd0, d); chk("post_rst_mem0", d, 8'h33);
      rd(10'd1, d); chk("post_rst_mem1", d, 8'h44);

      // Full-depth load (LEN = 64)
      pulse_load();
      send_byte(8'h40, 1'b1);
      x = 8'h00;
      for (int k = 0; k < 64; k++) begin
         send_byte(8'(k * 3 + 1), 1'b1);
         x = x ^ 8'(k * 3 + 1);
      end
      chk("full_busy_csum", {7'd0, busy}, 8'd1);
      send_byte(x, 1'b1);
      repeat (2) @(negedge clk);
      chk("full_done", {7'd0, done}, 8'd1);
      rd(10'd0, d);  chk("full_mem0", d, 8'h01);
      rd(10'd63, d); chk("full_mem63", d, 8'hBE);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
